fpu_div_arbiter: RTL and testbench

Controller that shares one iterative floating-point `divider` instance between `NUM_REQ` requesters. It arbitrates round-robin among pending requests and latches the winner's IEEE-754 operands onto the divider. It restarts the divider with a one-cycle reset pulse and waits a fixed `DIV_LATENCY` cycles. It then returns the quotient and flags on a single tagged response port with a valid/ready handshake. It sits between the FPU issue logic and the `divider` datapath.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/rr_arb.sv | 32 +++
 rtl/fpu_div_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fpu_div_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU divider arbiter.
// Float width, state encoding and special IEEE-754 patterns.
package fpu_pkg;

  localparam int FP_W = 32;

  localparam logic [7:0] FP_EXP_INF = 8'hFF;

  localparam logic [FP_W-1:0] FP_QNAN =
    32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_state_t;

  // 0/0 gives qNaN, x/0 gives signed infinity
  function automatic logic [FP_W-1:0]
    fp_zdiv_result(
      input logic [FP_W-1:0] dd,
      input logic [FP_W-1:0] ds
    );
    logic [FP_W-1:0] r;
    if (dd[30:0] == 31'd0) begin
      r = FP_QNAN;
    end else begin
      r = {dd[31] ^ ds[31],
           FP_EXP_INF,
           23'd0};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin select: first set
// request at or after ptr, wrapping around.
module rr_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // scan from the far end so the nearest hit wins
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one iterative FP divider among NUM_REQ requesters.
// Optional FPU_DIV_ZERO_SHORTCUT_EN: answer zero divisors directly.
module fpu_div_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DIV_LATENCY = 100,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(DIV_LATENCY)
) (
  input  logic                    control,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_dd,
  input  logic [32*NUM_REQ-1:0]   req_ds,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IW-1:0]           rsp_id,
  output logic [FP_W-1:0]         rsp_out,
  output logic                    rsp_exception,
  output logic                    rsp_zerodiv,
  output logic [FP_W-1:0]         div_dd,
  output logic [FP_W-1:0]         div_ds,
  output logic                    div_reset,
  input  logic [FP_W-1:0]         div_out,
  input  logic                    div_exception,
  input  logic                    div_zerodiv
);

  div_state_t r_state;
  div_state_t w_state_nxt;

  logic [IW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [FP_W-1:0] r_op_dd;
  logic [FP_W-1:0] r_op_ds;
  logic [FP_W-1:0] r_rsp_out;
  logic [IW-1:0]   r_rsp_id;
  logic            r_rsp_exc;
  logic            r_rsp_zd;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_ptr_nxt;
  logic [FP_W-1:0]    w_sel_dd;
  logic [FP_W-1:0]    w_sel_ds;
  logic               w_accept;
  logic               w_term;
  logic               w_zero_sc;

  rr_arb #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arb (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_sel_dd =
    req_dd[32*int'(w_idx) +: 32];
  assign w_sel_ds =
    req_ds[32*int'(w_idx) +: 32];

  assign w_accept =
    (r_state == IDLE) && (|req_valid);

  assign w_term =
    (r_state == WAIT) &&
    (r_cnt == CW'(DIV_LATENCY - 1));

  assign w_ptr_nxt =
    (w_idx == IW'(NUM_REQ - 1)) ?
    '0 : w_idx + 1'b1;

`ifdef FPU_DIV_ZERO_SHORTCUT_EN
  assign w_zero_sc =
    (w_sel_ds[30:0] == 31'd0);
`else
  assign w_zero_sc = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt =
            w_zero_sc ? RESP : START;
        end
      end
      START: w_state_nxt = WAIT;
      WAIT: begin
        if (w_term) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_op_dd   <= '0;
      r_op_ds   <= '0;
      r_rsp_out <= '0;
      r_rsp_id  <= '0;
      r_rsp_exc <= 1'b0;
      r_rsp_zd  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
        r_rsp_id <= w_idx;
        // shortcut leaves the divider inputs alone
        if (w_zero_sc) begin
          r_rsp_out <=
            fp_zdiv_result(w_sel_dd, w_sel_ds);
          r_rsp_exc <= 1'b1;
          r_rsp_zd  <= 1'b1;
        end else begin
          r_op_dd <= w_sel_dd;
          r_op_ds <= w_sel_ds;
        end
      end
      if (r_state == WAIT) begin
        r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      end
      if (w_term) begin
        r_rsp_out <= div_out;
        r_rsp_exc <= div_exception;
        r_rsp_zd  <= div_zerodiv;
      end
    end
  end

  assign req_ready =
    w_accept ? w_gnt : '0;

  assign rsp_valid     = (r_state == RESP);
  assign rsp_id        = r_rsp_id;
  assign rsp_out       = r_rsp_out;
  assign rsp_exception = r_rsp_exc;
  assign rsp_zerodiv   = r_rsp_zd;

  assign div_dd = r_op_dd;
  assign div_ds = r_op_ds;

  assign div_reset =
    (r_state == START) | ~reset;

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Bench for fpu_div_arbiter: stub divider, transaction
// model of grants/latency, directed and random traffic.
module tb_fpu_div_arbiter;

  localparam int N = 2;
  localparam int L = 100;

  logic            control = 1'b0;
  logic            reset   = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_dd = '0;
  logic [32*N-1:0] req_ds = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_out;
  logic            rsp_exception;
  logic            rsp_zerodiv;
  logic [31:0]     div_dd;
  logic [31:0]     div_ds;
  logic            div_reset;
  logic [31:0]     div_out;
  logic            div_exception;
  logic            div_zerodiv;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_cnt = 0;
  int gnt_log[$];

  fpu_div_arbiter #(
    .NUM_REQ     (N),
    .DIV_LATENCY (L)
  ) dut (
    .control       (control),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dd        (req_dd),
    .req_ds        (req_ds),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_out       (rsp_out),
    .rsp_exception (rsp_exception),
    .rsp_zerodiv   (rsp_zerodiv),
    .div_dd        (div_dd),
    .div_ds        (div_ds),
    .div_reset     (div_reset),
    .div_out       (div_out),
    .div_exception (div_exception),
    .div_zerodiv   (div_zerodiv)
  );

  always #5 control = ~control;
  always @(posedge control) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] stub_q(
    input logic [31:0] dd,
    input logic [31:0] ds
  );
    return dd ^ {ds[15:0], ds[31:16]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic stub_e(
    input logic [31:0] dd,
    input logic [31:0] ds
  );
    return dd[31] ^ ds[31] ^ ds[0];
  endfunction

  function automatic logic stub_z(
    input logic [31:0] ds
  );
    return ds[30:0] == 31'd0;
  endfunction

  // stub divider: settles L cycles after its reset pulse
  logic [31:0] s_dd  = '0;
  logic [31:0] s_ds  = '0;
  int          s_cnt = L;
  logic        s_act = 1'b0;
  logic        s_ok;

  always @(posedge control) begin
    if (div_reset) begin
      s_dd  <= div_dd;
      s_ds  <= div_ds;
      s_cnt <= 0;
      s_act <= reset;
    end else if (s_cnt < L) begin
      s_cnt <= s_cnt + 1;
    end
  end

  assign s_ok = s_act && (s_cnt >= L - 1);
  assign div_out = s_ok ?
    stub_q(s_dd, s_ds) : ~stub_q(s_dd, s_ds);
  assign div_exception = s_ok ?
    stub_e(s_dd, s_ds) : ~stub_e(s_dd, s_ds);
  assign div_zerodiv = s_ok ?
    stub_z(s_ds) : ~stub_z(s_ds);

  // transaction model
  logic        m_busy  = 1'b0;
  int          m_ptr   = 0;
  int          m_acc   = 0;
  int          m_lat   = 0;
  logic        m_pulse = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_out   = '0;
  logic        m_exc   = 1'b0;
  logic        m_zd    = 1'b0;

  always @(negedge control) begin : mon
    int          g;
    int          j;
    logic [N-1:0] e_ready;
    logic        e_vld;
    logic [31:0] dd;
    logic [31:0] ds;
    if (!reset) begin
      chk("rst_req_ready", 64'(req_ready), 0);
      chk("rst_div_reset", 64'(div_reset), 1);
      chk("rst_rsp_valid", 64'(rsp_valid), 0);
      chk("rst_rsp_out", 64'(rsp_out), 0);
      chk("rst_rsp_id", 64'(rsp_id), 0);
      chk("rst_rsp_exc", 64'(rsp_exception), 0);
      chk("rst_rsp_zd", 64'(rsp_zerodiv), 0);
      chk("rst_div_dd", 64'(div_dd), 0);
      chk("rst_div_ds", 64'(div_ds), 0);
      m_busy = 1'b0;
      m_ptr  = 0;
    end else begin
      g = -1;
      e_ready = '0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (req_valid[j] && g < 0) g = j;
        end
      end
      if (g >= 0) e_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      e_vld = m_busy && (cyc - m_acc >= m_lat);
      chk("rsp_valid", 64'(rsp_valid), 64'(e_vld));
      chk("div_reset", 64'(div_reset),
          64'(m_busy && m_pulse && cyc == m_acc + 1));
      if (e_vld) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_out", 64'(rsp_out), 64'(m_out));
        chk("rsp_exc", 64'(rsp_exception), 64'(m_exc));
        chk("rsp_zd", 64'(rsp_zerodiv), 64'(m_zd));
      end
      if (s_act && !div_reset && s_cnt <= L - 1) begin
        chk("dd_stable", 64'(div_dd), 64'(s_dd));
        chk("ds_stable", 64'(div_ds), 64'(s_ds));
      end
      if (div_reset) pulse_cnt++;
      if (e_vld && rsp_ready) m_busy = 1'b0;
      if (g >= 0) begin
        dd = req_dd[32*g +: 32];
        ds = req_ds[32*g +: 32];
        m_busy = 1'b1;
        m_acc  = cyc;
        m_ptr  = (g + 1) % N;
        m_id   = g;
        gnt_log.push_back(g);
        m_lat   = L + 2;
        m_pulse = 1'b1;
        m_out   = stub_q(dd, ds);
        m_exc   = stub_e(dd, ds);
        m_zd    = stub_z(ds);
`ifdef FPU_DIV_ZERO_SHORTCUT_EN
        if (ds[30:0] == 31'd0) begin
          m_lat   = 1;
          m_pulse = 1'b0;
          m_exc   = 1'b1;
          m_zd    = 1'b1;
          if (dd[30:0] == 31'd0)
            m_out = 32'h7FC0_0000;
          else
            m_out = {dd[31] ^ ds[31], 8'hFF, 23'd0};
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge control);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick(1);
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic set_req(
    input int          i,
    input logic [31:0] dd,
    input logic [31:0] ds
  );
    req_dd[32*i +: 32] = dd;
    req_ds[32*i +: 32] = ds;
  endtask

  task automatic one_op(
    input logic [31:0] dd,
    input logic [31:0] ds,
    input int          exp_lat,
    input logic [31:0] exp_out,
    input logic        exp_exc,
    input int          exp_pulses
  );
    int n;
    set_req(0, dd, ds);
    pulse_cnt = 0;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick(1);
    req_valid = '0;
    wait_rsp(n);
    chk("lat", 64'(n + 1), 64'(exp_lat));
    chk("op_id", 64'(rsp_id), 0);
    chk("op_out", 64'(rsp_out), 64'(exp_out));
    chk("op_exc", 64'(rsp_exception), 64'(exp_exc));
    chk("op_pulses", 64'(pulse_cnt), 64'(exp_pulses));
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    int n;
    int zlat;
    int zp;
    logic [31:0] zout;
    logic [31:0] zout0;
    logic        zexc;
    logic        zexc0;
    tick(3);
    reset = 1'b1;
    tick(2);

    // single request
    one_op(32'h4012_C000, 32'hC33B_660A, L + 2,
           stub_q(32'h4012_C000, 32'hC33B_660A),
           stub_e(32'h4012_C000, 32'hC33B_660A), 1);

    // contention from reset
    reset = 1'b0;
    tick(2);
    set_req(0, 32'h4235_6000, 32'h4140_0000);
    set_req(1, 32'h4012_C000, 32'hC33B_660A);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    gnt_log.delete();
    reset = 1'b1;
    n = 0;
    while (gnt_log.size() < 4 && n < 1000) begin
      tick(1);
      n++;
    end
    if (gnt_log.size() < 4) begin
      chk("gnt_timeout", 0, 1);
    end else begin
      for (int i = 0; i < 4; i++)
        chk("gnt_order", 64'(gnt_log[i]), 64'(i % 2));
    end
    req_valid = '0;
    tick(L + 6);

    // backpressure; pointer now at 0
    set_req(0, 32'h3FC0_0000, 32'h4080_0000);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b11;
    wait_rsp(n);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out", 64'(rsp_out),
          64'(stub_q(32'h3FC0_0000, 32'h4080_0000)));
      chk("bp_ready", 64'(req_ready), 0);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(1);
    chk("bp_next_gnt", 64'(req_ready), 64'(2'b10));
    tick(1);
    req_valid = '0;
    tick(L + 6);

    // reset mid-WAIT
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    tick(1);
    req_valid = '0;
    tick(48);
    reset = 1'b0;
    #1;
    chk("mr_div_reset", 64'(div_reset), 1);
    chk("mr_rsp_valid", 64'(rsp_valid), 0);
    chk("mr_req_ready", 64'(req_ready), 0);
    tick(3);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("mr_gnt0", 64'(req_ready), 64'(2'b01));
    tick(1);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(L + 6);
    rsp_ready = 1'b0;

    // zero divisor, nonzero and zero dividend
`ifdef FPU_DIV_ZERO_SHORTCUT_EN
    zlat = 1;
    zp   = 0;
    zout  = 32'hFF80_0000;
    zout0 = 32'h7FC0_0000;
    zexc  = 1'b1;
    zexc0 = 1'b1;
`else
    zlat = L + 2;
    zp   = 1;
    zout  = stub_q(32'h3F80_0000, 32'h8000_0000);
    zout0 = stub_q(32'h0, 32'h8000_0000);
    zexc  = stub_e(32'h3F80_0000, 32'h8000_0000);
    zexc0 = stub_e(32'h0, 32'h8000_0000);
`endif
    one_op(32'h3F80_0000, 32'h8000_0000,
           zlat, zout, zexc, zp);
    chk("zd_flag", 64'(rsp_zerodiv), 1);
    one_op(32'h0, 32'h8000_0000,
           zlat, zout0, zexc0, zp);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        set_req(i,
          ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
          ($urandom_range(0, 7) == 0) ?
            {$urandom_range(0, 1) == 1, 31'd0} :
            $urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick(L + 6);

    @(negedge control);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
